// File: rtl/sik_pkg.sv
// Definitions shared by the SIK fetch stage and the execute core: word/PC sizes,
// instruction fields, opcodes, NoArg sub-opcodes and the fetch state encoding.
package sik_pkg;

    localparam int unsigned WORDSIZE = 16;
    localparam int unsigned PCSIZE   = 16;

    localparam int unsigned OPCODE_HI = 15;
    localparam int unsigned OPCODE_LO = 12;
    localparam int unsigned ARG_HI    = 11;
    localparam int unsigned ARG_LO    = 0;

    typedef enum logic [3:0] {
        OP_NOARG = 4'd1,
        OP_PUSH  = 4'd2,
        OP_JUMP  = 4'd3,
        OP_JUMPT = 4'd4,
        OP_JUMPF = 4'd5,
        OP_CALL  = 4'd6,
        OP_LOAD  = 4'd7,
        OP_STORE = 4'd8,
        OP_GET   = 4'd9,
        OP_PUT   = 4'd10
    } opcode_e;

    // NoArg sub-opcodes live in the argument field
    typedef enum logic [11:0] {
        SUB_RET  = 12'd0,
        SUB_ADD  = 12'd1,
        SUB_SUB  = 12'd2,
        SUB_MUL  = 12'd3,
        SUB_AND  = 12'd4,
        SUB_OR   = 12'd5,
        SUB_XOR  = 12'd6,
        SUB_NOT  = 12'd7,
        SUB_DUP  = 12'd8,
        SUB_DROP = 12'd9,
        SUB_SWAP = 12'd10,
        SUB_SYS  = 12'd11
    } noarg_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic opcode_e get_opcode(input logic [WORDSIZE-1:0] word);
        return opcode_e'(word[OPCODE_HI:OPCODE_LO]);
    endfunction

endpackage

// File: rtl/sik_fetch_if.sv
// Fetch-stage bus: execute control, instruction-memory read port and the
// instruction handoff. master = fetch stage, slave = memory/execute side.
interface sik_fetch_if;
    import sik_pkg::*;

    logic                redirect;
    logic [PCSIZE-1:0]   redirect_pc;
    logic                stop;
    logic                imem_req;
    logic [PCSIZE-1:0]   imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [WORDSIZE-1:0] imem_rdata;
    logic                inst_valid;
    logic [WORDSIZE-1:0] inst;
    logic [PCSIZE-1:0]   inst_pc;
    logic                inst_ready;

    modport master (
        input  redirect, redirect_pc, stop, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect, redirect_pc, stop, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/sik_fifo.sv
// Synchronous FIFO with flush, occupancy count and same-cycle push/pop
// (push into a full FIFO is accepted when a pop happens in the same cycle).
module sik_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (32'(p) == DEPTH - 1) return '0;
        return p + AW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/sik_fetch.sv
// SIK instruction fetch/prefetch: sequential imem reads into an in-order queue,
// PC-tagged handoff to execute, flush and stale-response drop on redirect.
module sik_fetch
    import sik_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       MAX_OUTST = 2,
    parameter logic [PCSIZE-1:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    sik_fetch_if.master bus
);

    localparam int unsigned QCW = $clog2(DEPTH+1);
    localparam int unsigned OCW = $clog2(MAX_OUTST+1);
    localparam int unsigned QW  = WORDSIZE + PCSIZE;

    logic [PCSIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0]    drop_q, drop_d;
    fetch_state_e      state_q, state_d;

    logic [QCW-1:0]    q_count;
    logic [QW-1:0]     q_head;
    logic              q_push, q_pop;
    logic [OCW-1:0]    outst;
    logic [PCSIZE-1:0] tag_pc;
    logic              req, fire, rsp_drop;

    // The tag queue holds one entry per in-flight read, so its occupancy is the
    // outstanding count; it is never flushed because stale responses still pop it.
    sik_fifo #(.WIDTH(PCSIZE), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (fire),
        .push_data (fetch_pc_q),
        .pop       (bus.imem_rvalid),
        .pop_data  (tag_pc),
        .count     (outst)
    );

    sik_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (q_push),
        .push_data ({bus.imem_rdata, tag_pc}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count)
    );

    always_comb begin
        req = !reset && (state_q == RUN) && !bus.redirect && !bus.stop &&
              ((32'(q_count) + 32'(outst)) < DEPTH) && (32'(outst) < MAX_OUTST);
        fire     = req && bus.imem_gnt;
        rsp_drop = (drop_q != '0);
        q_push   = bus.imem_rvalid && !rsp_drop && !bus.redirect;
        q_pop    = (q_count != '0) && bus.inst_ready;

        fetch_pc_d = fetch_pc_q;
        if (fire) fetch_pc_d = fetch_pc_q + 16'd1;
        if (bus.redirect) fetch_pc_d = bus.redirect_pc;

        drop_d = drop_q;
        if (bus.redirect) drop_d = outst - OCW'(bus.imem_rvalid);
        else if (bus.imem_rvalid && rsp_drop) drop_d = drop_q - OCW'(1);

        state_d = bus.stop ? HALTED : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
            state_q    <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (q_count != '0);
    assign bus.inst       = q_head[QW-1:PCSIZE];
    assign bus.inst_pc    = q_head[PCSIZE-1:0];

endmodule

// File: tb/tb_sik_fetch.sv
// Self-checking bench for sik_fetch: random-latency memory, random handshakes and
// redirects, compared each cycle against a queue-based model of the fetch stage.
module tb_sik_fetch;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sik_fetch_if bus ();

    sik_fetch #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: in-flight reads carry their PC and a stale flag set by redirect.
    typedef struct {
        logic [15:0] pc;
        bit          stale;
    } flight_t;

    flight_t     fl[$];
    logic [31:0] iq[$];
    logic [15:0] m_pc;
    bit          m_halt;
    bit          m_zero;
    logic [15:0] pend[$];

    int unsigned gnt_pct = 100;
    int unsigned rsp_pct = 100;
    int unsigned rdy_pct = 100;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h9000 + a;
    endfunction

    task automatic model_reset();
        fl.delete();
        iq.delete();
        m_pc   = RESET_PC;
        m_halt = 0;
        m_zero = 1;
    endtask

    task automatic step();
        bit          exp_req;
        bit          req_a;
        logic [15:0] addr_a;
        flight_t     f;
        bus.imem_gnt   = ($urandom_range(99) < gnt_pct);
        bus.inst_ready = ($urandom_range(99) < rdy_pct);
        if (!rst && pend.size() != 0 && $urandom_range(99) < rsp_pct) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
        exp_req = !rst && !m_halt && !bus.redirect && !bus.stop &&
                  (iq.size() + fl.size() < DEPTH) && (fl.size() < MAX_OUTST);
        check_eq("imem_req", bus.imem_req, exp_req);
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("inst_valid", bus.inst_valid, iq.size() != 0);
        if (iq.size() != 0) begin
            check_eq("inst", bus.inst, iq[0][31:16]);
            check_eq("inst_pc", bus.inst_pc, iq[0][15:0]);
        end else if (m_zero) begin
            check_eq("inst_rst", bus.inst, 0);
            check_eq("inst_pc_rst", bus.inst_pc, 0);
        end
        req_a  = bus.imem_req;
        addr_a = bus.imem_addr;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            model_reset();
        end else begin
            if (bus.imem_rvalid) void'(pend.pop_front());
            if (req_a && bus.imem_gnt) pend.push_back(addr_a);
            if (iq.size() != 0 && bus.inst_ready) void'(iq.pop_front());
            if (bus.imem_rvalid && fl.size() != 0) begin
                f = fl.pop_front();
                if (!f.stale && !bus.redirect) begin
                    iq.push_back({bus.imem_rdata, f.pc});
                    m_zero = 0;
                end
            end
            if (exp_req && bus.imem_gnt) begin
                fl.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 16'd1;
            end
            if (bus.redirect) begin
                iq.delete();
                foreach (fl[i]) fl[i].stale = 1;
                m_pc = bus.redirect_pc;
            end
            if (bus.stop) m_halt = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst              = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.stop         = 1'b0;
        bus.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = '0;
        bus.inst_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        repeat (2) step();
        rst = 1'b0;

        // Single-cycle memory, always ready: back-to-back instructions
        repeat (30) step();

        // Execute stalls: queue fills to DEPTH, requests stop, then drains in order
        rdy_pct = 0;
        repeat (12) step();
        rdy_pct = 100;
        repeat (12) step();

        // Two reads in flight to 5 and 6, then redirect to 0x100
        gnt_pct = 0;
        repeat (3) step();
        gnt_pct = 100;
        rsp_pct = 0;
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0005;
        step();
        bus.redirect = 1'b0;
        repeat (3) step();
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
        step();
        bus.redirect = 1'b0;
        rsp_pct = 100;
        repeat (10) step();

        // PC wrap
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
        step();
        bus.redirect = 1'b0;
        repeat (10) step();

        // Random traffic with occasional redirects
        gnt_pct = 70; rsp_pct = 60; rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            bus.redirect    = ($urandom_range(24) == 0);
            bus.redirect_pc = ($urandom_range(3) == 0) ? 16'(16'hFFFC + $urandom_range(3))
                                                        : 16'($urandom);
            step();
        end
        bus.redirect = 1'b0;

        // Reset with the queue full
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        rdy_pct = 100;
        repeat (10) step();

        // Stop with three words queued: no more requests, queue drains, then idle
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy_pct = 0;
        for (int i = 0; i < 20 && iq.size() != 3; i++) step();
        if (iq.size() != 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL stop_setup: queue depth %0d expected 3", iq.size());
        end
        bus.stop = 1'b1;
        repeat (3) step();
        rdy_pct = 100;
        repeat (12) step();
        check_eq("halted_idle_valid", bus.inst_valid, 0);
        check_eq("halted_idle_req", bus.imem_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sik_fetch.md
Name: sik_fetch

Overview:
- Instruction fetch and prefetch stage that sits directly upstream of the SIK stack-processor execute core.
- Issues sequential 16-bit instruction reads to instruction memory and buffers the returned words in an in-order prefetch queue.
- Hands each instruction, tagged with its PC, to execute over a valid/ready handshake.
- On a control-flow redirect (Jump/JumpT/JumpF taken, Call, Ret), execute supplies a new PC; the stage flushes the queue and discards any in-flight memory responses.

Parameters:
- DEPTH, 4, prefetch queue entries (power of 2, 2..16).
- MAX_OUTST, 2, maximum outstanding memory reads (1..DEPTH).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  execute requests a PC change this cycle.
- redirect_pc  in  16  new fetch address; valid when redirect=1.
- stop  in  1  level; execute has halted (Sys). Stop issuing requests.
- imem_req  out  1  read request valid.
- imem_addr  out  16  read address; valid when imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data returning; responses come back in request order.
- imem_rdata  in  16  instruction word.
- inst_valid  out  1  queue head valid.
- inst  out  16  head instruction; [15:12] opcode, [11:0] argument.
- inst_pc  out  16  address the head instruction was fetched from.
- inst_ready  in  1  execute consumes the head this cycle.

Behaviour:
- Reset (dominates all other inputs):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0; state = RUN.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0.
  - A reset mid-operation abandons everything. Responses that arrive after reset are dropped only while drop_cnt > 0; since drop_cnt is cleared, memory must be reset at the same time.
- States:
  - RUN: normal fetching.
  - HALTED: entered when stop=1; imem_req = 0; the queue still drains to execute; in-flight responses are still accepted.
  - Leaves HALTED only on reset.
- Request rule:
  - imem_req = 1 in RUN when (count + outstanding) < DEPTH and outstanding < MAX_OUTST and redirect = 0 and stop = 0.
  - imem_addr = fetch_pc. imem_req/imem_addr hold stable until imem_gnt.
  - On imem_req & imem_gnt: fetch_pc += 1 (16-bit wrap, 16'hFFFF -> 16'h0000); outstanding += 1.
- Response rule:
  - Each imem_rvalid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise it is pushed as {imem_rdata, pc}. pc comes from a parallel in-order tag queue of issued addresses, depth MAX_OUTST.
  - The credit rule guarantees a push never overflows the queue.
- Output rule:
  - inst_valid = (count != 0), registered, driven from the queue head.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle are legal, including when the queue is full or empty. An empty queue with a push in the same cycle does not bypass: the word becomes visible on the next cycle, so minimum latency is imem_rvalid -> inst_valid of 1 cycle.
- Redirect (takes effect at the clock edge):
  - Queue is flushed (count = 0); fetch_pc = redirect_pc.
  - drop_cnt = outstanding after this cycle's updates, i.e. outstanding − (imem_rvalid ? 1 : 0) + 0. No new request is granted, since imem_req = 0 during redirect.
  - A pop in the same cycle is still counted as consumed.
  - A response in the same cycle is discarded.
  - The first request to redirect_pc is issued on the next cycle.
- Simultaneous stop and redirect: redirect updates fetch_pc and flushes the queue; the state still goes to HALTED.
- Throughput: with single-cycle memory, gnt always 1 and inst_ready always 1, the stage sustains 1 instruction/cycle once MAX_OUTST ≥ 2.

Decomposition:
- Shared package sik_pkg:
  - WORDSIZE = 16, PCSIZE = 16.
  - OPCODE/ARG field ranges.
  - Opcode constants (NoArg = 1 … Put = 10) and the NoArg sub-opcodes, so that execute and fetch share one definition.
  - Fetch state enum {RUN, HALTED}.
- One sub-module: sik_fifo.
  - Parameterized width/depth synchronous FIFO with flush input, count output, and simultaneous push/pop.
  - Instantiated twice: the instruction queue (width 32) and the PC tag queue (width 16, depth MAX_OUTST).

Test Plan:
- Reset, then 1-cycle memory returning mem[a] = 16'h9000 + a, inst_ready = 1 → imem_addr sequence 0, 1, 2…; inst/inst_pc pairs (16'h9000, 0), (16'h9001, 1)… with no gaps after the first.
- Hold inst_ready = 0 → exactly 4 words are queued (count + outstanding never exceeds 4); imem_req drops to 0; on release, words come out in order with no loss.
- With 2 reads outstanding to addresses 5 and 6, pulse redirect with redirect_pc = 16'h0100 → both late responses are discarded; next inst_pc = 16'h0100 with mem[0x100]; the queue was empty the cycle after redirect.
- Start at fetch_pc = 16'hFFFE → fetch addresses FFFE, FFFF, 0000; inst_pc values match.
- stop = 1 while 3 words are queued → no further imem_req; the 3 words drain; inst_valid then stays 0.
- Assert reset mid-stream with the queue full → the next cycle shows inst_valid = 0 and imem_req = 0; fetch restarts at RESET_PC.
